// File: rtl/seq_count_checker.sv
// Receive-side checker for the free-running 8-bit +1 count pattern: locks, then counts mismatches.
// Define SEQ_CHECK_ERR_SAT_EN to make err_count saturate; by default it wraps.
//
// state  | meaning
// HUNT   | no reference; next valid sample seeds the expected byte
// ACQ    | building a run of consecutive +1 samples toward LOCK_N
// LOCKED | tracking; mismatches are counted, UNLOCK_N in a row drop lock
module seq_count_checker #(
    parameter int LOCK_N   = 4,
    parameter int UNLOCK_N = 3,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_C   = 4'(LOCK_N);
    localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_N);

    state_t           cur, nxt;
    logic [7:0]       exp_q, exp_d;
    logic [3:0]       good_q, good_d;
    logic [3:0]       bad_q, bad_d;
    logic             miss;
    logic [ERR_W-1:0] cnt_base, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= HUNT;
            exp_q     <= 8'd0;
            good_q    <= 4'd0;
            bad_q     <= 4'd0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            cur       <= nxt;
            exp_q     <= exp_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            err_pulse <= miss;
            err_count <= cnt_d;
        end
    end

    always_comb begin
        nxt    = cur;
        exp_d  = exp_q;
        good_d = good_q;
        bad_d  = bad_q;
        miss   = 1'b0;
        if (din_valid) begin
            unique case (cur)
                HUNT: begin
                    exp_d  = din + 8'd1;
                    good_d = 4'd1;
                    nxt    = ACQ;
                end
                ACQ: begin
                    exp_d = din + 8'd1;
                    if (din == exp_q) begin
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == LOCK_C) begin
                            nxt   = LOCKED;
                            bad_d = 4'd0;
                        end
                    end else begin
                        good_d = 4'd1;
                    end
                end
                LOCKED: begin
                    // No resync while locked: a slipped source keeps erroring until unlock.
                    exp_d = exp_q + 8'd1;
                    if (din == exp_q) begin
                        bad_d = 4'd0;
                    end else begin
                        miss  = 1'b1;
                        bad_d = bad_q + 4'd1;
                        if (bad_q + 4'd1 == UNLOCK_C) nxt = HUNT;
                    end
                end
                default: nxt = HUNT;
            endcase
        end
    end

    // Clear applies first so a simultaneous counted mismatch leaves a count of 1.
    always_comb begin
        cnt_base = clear ? '0 : err_count;
        cnt_d    = cnt_base;
        if (miss) begin
`ifdef SEQ_CHECK_ERR_SAT_EN
            if (!(&cnt_base)) cnt_d = cnt_base + ERR_W'(1);
`else
            cnt_d = cnt_base + ERR_W'(1);
`endif
        end
    end

    assign locked = (cur == LOCKED);
    assign state  = cur;

endmodule

// File: tb/tb_seq_count_checker.sv
// Self-checking bench for seq_count_checker: vector table, directed corner cases and a random run
// against a behavioural model; a second small instance exercises err_count wrap/saturation.
module tb_seq_count_checker;

    localparam int LOCK_N   = 4;
    localparam int UNLOCK_N = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din = 8'd0;
    logic        din_valid = 1'b0;
    logic        clear = 1'b0;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic [1:0]  state;

    logic [7:0]  din1 = 8'd0;
    logic        valid1 = 1'b0;
    logic        clear1 = 1'b0;
    logic        locked1, pulse1;
    logic [3:0]  cnt1;
    logic [1:0]  state1;

    seq_count_checker #(.LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .ERR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .state(state)
    );

    seq_count_checker #(.LOCK_N(4), .UNLOCK_N(15), .ERR_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(valid1), .clear(clear1),
        .locked(locked1), .err_pulse(pulse1), .err_count(cnt1), .state(state1)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: mode 0=hunting, 1=acquiring, 2=locked
    int m_mode, m_exp, m_good, m_bad, m_cnt, m_pulse;

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         c;
        bit         lk;
        int         st;
        bit         pl;
        int         cnt;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_exp = 0; m_good = 0; m_bad = 0; m_cnt = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit c);
        m_pulse = 0;
        if (c) m_cnt = 0;
        if (v) begin
            if (m_mode == 0) begin
                m_exp = (d + 1) % 256; m_good = 1; m_mode = 1;
            end else if (m_mode == 1) begin
                if (d == m_exp) begin
                    m_good++;
                    if (m_good == LOCK_N) begin m_mode = 2; m_bad = 0; end
                end else begin
                    m_good = 1;
                end
                m_exp = (d + 1) % 256;
            end else begin
                if (d == m_exp) m_bad = 0;
                else begin
                    m_pulse = 1;
                    m_cnt = (m_cnt + 1) % 65536;
                    m_bad++;
                    if (m_bad == UNLOCK_N) m_mode = 0;
                end
                m_exp = (m_exp + 1) % 256;
            end
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit c);
        din_valid = v; din = d; clear = c;
        @(posedge clk);
        model_step(v, int'(d), c);
        #1;
        check("model_locked", int'(locked), (m_mode == 2) ? 1 : 0);
        check("model_state", int'(state), m_mode);
        check("model_pulse", int'(err_pulse), m_pulse);
        check("model_count", int'(err_count), m_cnt);
    endtask

    task automatic do_reset();
        din_valid = 1'b0; clear = 1'b0; valid1 = 1'b0; clear1 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_locked", int'(locked), 0);
        check("rst_state", int'(state), 0);
        check("rst_pulse", int'(err_pulse), 0);
        check("rst_count", int'(err_count), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step1(input bit v, input logic [7:0] d);
        valid1 = v; din1 = d; clear1 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] e;
        int dv;
        bit vv, cc;

        model_reset();
        tbl[0]  = '{1'b1, 8'h10, 1'b0, 1'b0, 1, 1'b0, 0};
        tbl[1]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 0};
        tbl[2]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1, 1'b0, 0};
        tbl[3]  = '{1'b1, 8'h13, 1'b0, 1'b1, 2, 1'b0, 0};
        tbl[4]  = '{1'b1, 8'h14, 1'b0, 1'b1, 2, 1'b0, 0};
        tbl[5]  = '{1'b1, 8'h55, 1'b0, 1'b1, 2, 1'b1, 1};
        tbl[6]  = '{1'b1, 8'h16, 1'b0, 1'b1, 2, 1'b0, 1};
        tbl[7]  = '{1'b0, 8'hAA, 1'b0, 1'b1, 2, 1'b0, 1};
        tbl[8]  = '{1'b1, 8'h17, 1'b1, 1'b1, 2, 1'b0, 0};
        tbl[9]  = '{1'b1, 8'h99, 1'b1, 1'b1, 2, 1'b1, 1};
        tbl[10] = '{1'b1, 8'h00, 1'b0, 1'b1, 2, 1'b1, 2};
        tbl[11] = '{1'b1, 8'h01, 1'b0, 1'b0, 0, 1'b1, 3};
        tbl[12] = '{1'b1, 8'h40, 1'b0, 1'b0, 1, 1'b0, 3};

        #1;
        check("rst_locked", int'(locked), 0);
        check("rst_count", int'(err_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].c);
            check($sformatf("tbl%0d_locked", i), int'(locked), int'(tbl[i].lk));
            check($sformatf("tbl%0d_state", i), int'(state), tbl[i].st);
            check($sformatf("tbl%0d_pulse", i), int'(err_pulse), int'(tbl[i].pl));
            check($sformatf("tbl%0d_count", i), int'(err_count), tbl[i].cnt);
        end
        // Relock after unlock: 8'h40 seeded, three more in sequence lock
        step(1, 8'h41, 0); step(1, 8'h42, 0);
        check("relock_not_yet", int'(locked), 0);
        step(1, 8'h43, 0);
        check("relock", int'(locked), 1);

        // Clean run from reset, 8'h10..8'h40
        do_reset();
        for (int i = 8'h10; i <= 8'h40; i++) begin
            step(1, 8'(i), 0);
            if (i < 8'h13) check("clean_unlocked", int'(locked), 0);
            else check("clean_locked", int'(state), 2);
        end
        check("clean_count", int'(err_count), 0);

        // Wrap-around 8'hFF -> 8'h00
        do_reset();
        for (int i = 8'hFC; i <= 8'hFF; i++) step(1, 8'(i), 0);
        step(1, 8'h00, 0); step(1, 8'h01, 0);
        check("wrap_locked", int'(locked), 1);
        check("wrap_count", int'(err_count), 0);

        // Valid gaps between 8'h30 and 8'h31
        do_reset();
        for (int i = 8'h2C; i <= 8'h30; i++) step(1, 8'(i), 0);
        for (int i = 0; i < 5; i++) step(0, 8'hAA, 0);
        step(1, 8'h31, 0);
        step(1, 8'h32, 0);
        check("gap_pulse", int'(err_pulse), 0);
        check("gap_count", int'(err_count), 0);
        check("gap_locked", int'(locked), 1);

        // Mid-operation reset, then random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            vv = ($urandom_range(0, 3) != 0);
            cc = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) dv = int'($urandom_range(0, 255));
            else dv = m_exp;
            step(vv, 8'(dv), cc);
        end

        // err_count wrap / saturation on the 4-bit instance
        do_reset();
        for (int i = 0; i < 4; i++) step1(1, 8'(i));
        check("small_locked", int'(locked1), 1);
        e = 8'h04;
        for (int i = 0; i < 20; i++) begin
            if (i == 14) begin step1(1, e); e = e + 8'd1; end
            step1(1, e ^ 8'h80);
            e = e + 8'd1;
        end
        check("small_pulse", int'(pulse1), 1);
        check("small_still_locked", int'(locked1), 1);
`ifdef SEQ_CHECK_ERR_SAT_EN
        check("small_count", int'(cnt1), 15);
`else
        check("small_count", int'(cnt1), 4);
`endif
        step1(0, 8'h00);
        check("small_pulse_drop", int'(pulse1), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
